// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// MMIO_CONSOLE_ADDR is only decoded when DMEM_MMIO_EN is defined.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [31:0] MMIO_CONSOLE_ADDR = 32'hFFFF_FFF0;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit word storage: synchronous byte-enabled write, combinational read.
// Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    input  logic [3:0]               be_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= byte_merge(mem_q[addr_i], wdata_i, be_i);
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder with req/ready handshake and range/alignment check.
// Optional console register at MMIO_CONSOLE_ADDR when DMEM_MMIO_EN is defined.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2,
    parameter logic [31:0] BASE    = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        stall
`ifdef DMEM_MMIO_EN
   ,output logic [7:0]  mmio_data,
    output logic        mmio_vld
`endif
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic          cur_we;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_off;
    logic [AW-1:0] cur_idx;
    logic          cur_mmio;
    logic          cur_err;
    logic [31:0]   arr_rdata;
    logic [31:0]   load_word;
    logic          arr_we;

    // Live inputs are only used in IDLE, where a LATENCY=1 request goes straight to RESP.
    always_comb begin
        cur_we   = (state_q == IDLE) ? we   : we_q;
        cur_addr = (state_q == IDLE) ? addr : addr_q;
        cur_off  = cur_addr - BASE;
        cur_idx  = cur_off[AW+1:2];
        cur_err  = !cur_mmio && ((cur_off >= SPAN) || (cur_addr[1:0] != 2'b00));
    end

`ifdef DMEM_MMIO_EN
    logic [7:0]  mmio_data_q, mmio_data_d;
    logic        mmio_vld_q, mmio_vld_d;
    logic [31:0] cur_wdata;

    assign cur_mmio  = (cur_addr == MMIO_CONSOLE_ADDR);
    assign cur_wdata = (state_q == IDLE) ? wdata : wdata_q;
    assign load_word = cur_mmio ? {24'h0, mmio_data_q} : arr_rdata;

    always_comb begin
        mmio_vld_d  = ready_d && cur_we && cur_mmio;
        mmio_data_d = mmio_vld_d ? cur_wdata[7:0] : mmio_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mmio_data_q <= 8'h00;
            mmio_vld_q  <= 1'b0;
        end else begin
            mmio_data_q <= mmio_data_d;
            mmio_vld_q  <= mmio_vld_d;
        end
    end

    assign mmio_data = mmio_data_q;
    assign mmio_vld  = mmio_vld_q;
`else
    assign cur_mmio  = 1'b0;
    assign load_word = arr_rdata;
`endif

    // Store commits on the edge that ends RESP; state_q==RESP implies cur_* are the latched copy.
    assign arr_we = (state_q == RESP) && we_q && !cur_err && !cur_mmio;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .addr_i  (cur_idx),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = be;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered: they are computed on the edge entering RESP.
        ready_d = (state_d == RESP);
        err_d   = ready_d && cur_err;
        rdata_d = (ready_d && !cur_we && !cur_err) ? load_word : 32'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready = ready_q;
    assign err   = err_q;
    assign rdata = rdata_q;
    assign stall = req & ~ready_q;

endmodule
